// File: rtl/seq_detect_fsm.sv
// Serial pattern detector with KMP-style fallback, optional overlapping
// detection, and a saturating match counter that can be cleared.
//
// The state is the number of pattern bits currently matched.
// Both transition tables are built from the parameters during elaboration.
module seq_detect_fsm #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       x1,
    input  logic                       clear_cnt,
    output logic                       match,
    output logic [$clog2(PAT_LEN)-1:0] state_idx,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int SW      = $clog2(PAT_LEN);
    localparam int PAT_INT = int'(PATTERN);

    // The number of states depends on PAT_LEN, so a fixed enum cannot list them.
    // A state is therefore just its match length.
    typedef logic [SW-1:0] state_t;

    localparam state_t     LAST_S  = SW'(PAT_LEN - 1);
    localparam state_t     ZERO_S  = '0;
    localparam logic       FINAL_B = PATTERN[0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Return pattern bit i, counted from the first bit expected (PATTERN MSB).
    function automatic int pbit(input int i);
        return (PAT_INT >> (PAT_LEN - 1 - i)) & 1;
    endfunction

    // Return the length of the longest pattern prefix (shorter than PAT_LEN)
    // that ends the received string. That string is the first k pattern bits
    // followed by the new bit b. Match lengths are tried from longest to
    // shortest, so the first hit is the largest one.
    // With k = PAT_LEN-1 and the final pattern bit, this gives the border
    // of the full pattern.
    function automatic int next_state_of(input int k, input int b);
        int res;
        int sidx;
        int sb;
        bit ok;
        res = 0;
        for (int j = PAT_LEN - 1; j >= 1; j--) begin
            if (j <= k + 1 && res == 0) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (i < j) begin
                        sidx = k + 1 - j + i;
                        sb   = (sidx == k) ? b : pbit(sidx);
                        if (sb != pbit(i)) ok = 1'b0;
                    end
                end
                if (ok) res = j;
            end
        end
        return res;
    endfunction

    localparam int     BORDER   = next_state_of(PAT_LEN - 1, int'(FINAL_B));
    localparam state_t BORDER_S = SW'(BORDER);

    state_t tab_zero [PAT_LEN];
    state_t tab_one  [PAT_LEN];

    for (genvar k = 0; k < PAT_LEN; k++) begin : g_tab
        localparam int N0 = next_state_of(k, 0);
        localparam int N1 = next_state_of(k, 1);
        assign tab_zero[k] = SW'(N0);
        assign tab_one[k]  = SW'(N1);
    end

    state_t           state_q;
    state_t           state_next;
    logic             hit_next;
    logic [CNT_W-1:0] cnt_next;

    assign state_idx = state_q;

    // Next-state, completion detection and counter update.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state_q;
        hit_next   = 1'b0;
        cnt_next   = match_cnt;
        if (en) begin
            if (state_q == LAST_S && x1 == FINAL_B) begin
                hit_next   = 1'b1;
                state_next = OVERLAP ? BORDER_S : ZERO_S;
            end else begin
                state_next = x1 ? tab_one[state_q] : tab_zero[state_q];
            end
        end
        if (clear_cnt) begin
            cnt_next = '0;
        end else if (hit_next && match_cnt != CNT_MAX) begin
            cnt_next = match_cnt + 1'b1;
        end
    end

    // State register and registered outputs; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the values
        // from before the edge, independent of statement order.
        if (reset) begin
            state_q   <= ZERO_S;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state_q   <= state_next;
            match     <= hit_next;
            match_cnt <= cnt_next;
            cnt_sat   <= (cnt_next == CNT_MAX);
        end
    end

endmodule
